// File: rtl/fir_pkg.sv
// Shared widths, coefficients, state type and recursion helper
// for the inverse of the 1,4,16,4,1 FIR.
package fir_pkg;

  localparam int YW = 32;
  localparam int XW = 4;
  localparam int AW = 34;

  localparam int C0 = 1;
  localparam int C1 = 4;
  localparam int C2 = 16;

  typedef enum logic {
    RUN,
    ERROR
  } deconv_state_t;

  // x_hat = y - C1*h1 - C2*h2 - C1*h3 - C0*h4
  // Worked in AW bits so y=2^32-1 stays positive
  // and cannot wrap into the legal 0..15 window.
  function automatic logic signed [AW-1:0] deconv_step(
    input logic [YW-1:0] y,
    input logic [XW-1:0] h1,
    input logic [XW-1:0] h2,
    input logic [XW-1:0] h3,
    input logic [XW-1:0] h4
  );
    logic [AW-1:0] acc;
    acc = AW'(y);
    acc = acc - (AW'(h1) << $clog2(C1));
    acc = acc - (AW'(h2) << $clog2(C2));
    acc = acc - (AW'(h3) << $clog2(C1));
    acc = acc - (AW'(h4) << $clog2(C0));
    return $signed(acc);
  endfunction

endpackage

// File: rtl/fir_deconv_hist.sv
// 4-deep history of recovered samples, h1 newest.
// Ports: clk, rst (sync, low), clr, en_i, d_i -> h1_o..h4_o.
module fir_deconv_hist
  import fir_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en_i,
  input  logic [XW-1:0] d_i,
  output logic [XW-1:0] h1_o,
  output logic [XW-1:0] h2_o,
  output logic [XW-1:0] h3_o,
  output logic [XW-1:0] h4_o
);

  logic [XW-1:0] h_q [4];

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      for (int i = 0; i < 4; i++) h_q[i] <= '0;
    end else if (en_i) begin
      h_q[0] <= d_i;
      h_q[1] <= h_q[0];
      h_q[2] <= h_q[1];
      h_q[3] <= h_q[2];
    end
  end

  assign h1_o = h_q[0];
  assign h2_o = h_q[1];
  assign h3_o = h_q[2];
  assign h4_o = h_q[3];

endmodule

// File: rtl/fir_deconv.sv
// Recovers 4-bit FIR inputs from the filtered stream;
// flags impossible samples and stalls until clr/rst.
// Ports: clk, rst, clr, y_valid/y_ready/y_data in,
// x_valid/x_ready/x_data out, err sticky flag.
module fir_deconv
  import fir_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          y_valid,
  output logic          y_ready,
  input  logic [YW-1:0] y_data,
  output logic          x_valid,
  input  logic          x_ready,
  output logic [XW-1:0] x_data,
  output logic          err
);

  deconv_state_t state_q;
  logic          x_valid_q;
  logic [XW-1:0] x_data_q;
  logic          err_q;

  logic [XW-1:0] h1, h2, h3, h4;
  logic signed [AW-1:0] x_hat_d;
  logic          good_d;
  logic          y_fire_d;
  logic          x_fire_d;

  assign x_hat_d = deconv_step(y_data, h1, h2, h3, h4);

  // good iff sign clear and nothing above the low XW bits
  assign good_d = !x_hat_d[AW-1] &&
                  (x_hat_d[AW-2:XW] == '0);

  assign y_ready  = (state_q == RUN) &&
                    (!x_valid_q || x_ready);
  assign y_fire_d = y_valid && y_ready;
  assign x_fire_d = x_valid_q && x_ready;

  fir_deconv_hist u_hist (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en_i (y_fire_d && good_d),
    .d_i  (x_hat_d[XW-1:0]),
    .h1_o (h1),
    .h2_o (h2),
    .h3_o (h3),
    .h4_o (h4)
  );

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      state_q   <= RUN;
      x_valid_q <= 1'b0;
      x_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (x_fire_d) x_valid_q <= 1'b0;
      if (y_fire_d) begin
        if (good_d) begin
          x_valid_q <= 1'b1;
          x_data_q  <= x_hat_d[XW-1:0];
        end else begin
          state_q <= ERROR;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign x_valid = x_valid_q;
  assign x_data  = x_data_q;
  assign err     = err_q;

endmodule

// File: tb/tb_fir_deconv.sv
// Random + directed check of fir_deconv against a
// forward-FIR reference model with a candidate search.
module tb_fir_deconv;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        y_valid;
  logic        y_ready;
  logic [31:0] y_data;
  logic        x_valid;
  logic        x_ready;
  logic [3:0]  x_data;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  // model: recovered inputs (newest first), pending outputs
  int q_out[$];
  int hist[$];
  bit errm = 1'b0;

  always #5 clk = ~clk;

  fir_deconv dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_data  (y_data),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .x_data  (x_data),
    .err     (err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int hx(input int i);
    return (i < hist.size()) ? hist[i] : 0;
  endfunction

  // forward FIR output if the next input were c
  function automatic longint fir(input int c);
    return longint'(c) + 4 * hx(0) + 16 * hx(1)
         + 4 * hx(2) + hx(3);
  endfunction

  // one clock: drive, check before edge, advance model
  task automatic step(input bit v, input logic [31:0] y,
                      input bit xr, input bit c,
                      input bit r);
    bit exp_rdy, xf, yf;
    int found;
    y_valid = v;
    y_data  = y;
    x_ready = xr;
    clr     = c;
    rst     = r;
    @(negedge clk);
    exp_rdy = !errm && (q_out.size() == 0 || xr);
    chk("y_ready", y_ready, exp_rdy);
    chk("x_valid", x_valid, q_out.size() != 0);
    chk("err", err, errm);
    if (q_out.size() != 0)
      chk("x_data", x_data, q_out[0]);
    xf = q_out.size() != 0 && xr;
    yf = v && exp_rdy;
    @(posedge clk);
    #1;
    if (!r || c) begin
      q_out.delete();
      hist.delete();
      errm = 1'b0;
    end else begin
      if (xf) void'(q_out.pop_front());
      if (yf) begin
        found = -1;
        for (int k = 0; k < 16; k++)
          if (fir(k) == longint'({32'd0, y}))
            found = k;
        if (found >= 0) begin
          q_out.push_back(found);
          hist.push_front(found);
          if (hist.size() > 4) void'(hist.pop_back());
        end else begin
          errm = 1'b1;
        end
      end
    end
  endtask

  task automatic feed(input logic [31:0] y);
    step(1'b1, y, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic pulse_clr();
    step(1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    logic [31:0] ys [6];
    int r;
    longint f0;
    logic [31:0] yv;

    rst = 1'b0; clr = 1'b0;
    y_valid = 1'b0; y_data = '0; x_ready = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("rst_xdata", x_data, 0);
    chk("rst_xvalid", x_valid, 0);
    chk("rst_err", err, 0);

    // impulse
    ys = '{1, 4, 16, 4, 1, 0};
    foreach (ys[i]) feed(ys[i]);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    pulse_clr();

    // impulse with 3-cycle backpressure
    feed(1);
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'd4, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 6; i++) feed(ys[i]);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    pulse_clr();

    // step response
    ys = '{15, 75, 315, 375, 390, 390};
    foreach (ys[i]) feed(ys[i]);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    pulse_clr();

    // out of range high, then clear and recover
    feed(16);
    chk("err_hi", err, 1);
    step(1'b1, 32'd1, 1'b1, 1'b0, 1'b1);
    pulse_clr();
    chk("clr_err", err, 0);
    feed(1);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    pulse_clr();

    // negative x_hat
    feed(1);
    feed(3);
    chk("err_neg", err, 1);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    pulse_clr();

    // huge y must not wrap to good
    feed(32'hFFFF_FFFF);
    chk("err_max", err, 1);
    pulse_clr();

    // reset mid-stream
    feed(1);
    feed(4);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    feed(1);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 39);
      f0 = fir(0);
      if (r == 0)
        yv = $urandom;
      else if (r == 1)
        yv = 32'(fir($urandom_range(16, 23)));
      else if (r == 2 && f0 > 0)
        yv = 32'(f0 - longint'($urandom_range(1, 3)));
      else
        yv = 32'(fir($urandom_range(0, 15)));
      step($urandom_range(0, 3) != 0, yv,
           $urandom_range(0, 2) != 0,
           (errm && $urandom_range(0, 3) == 0) ||
             $urandom_range(0, 299) == 0,
           $urandom_range(0, 599) != 0);
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fir_deconv.md
Name: fir_deconv

Overview:
- Inverse (deconvolution) stage for the 5-tap symmetric FIR with coefficients 1,4,16,4,1.
- Takes the FIR's 32-bit output sample stream and recovers the original 4-bit unsigned input samples exactly, using integer recursion.
- Sits on the receive side of a link that carries FIR-filtered data, or in a loopback bench after the FIR.
- Detects sample streams that no valid 4-bit input could have produced, flags them, and stalls until cleared.

Parameters:
- YW, 32, width of the filtered input sample y.
- XW, 4, width of the recovered unsigned sample x.
- AW, 34, signed accumulator width for the recursion; must be at least YW+2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (reset when rst=0 at posedge clk).
- clr  in  1  synchronous clear: zeroes history, clears err, returns FSM to RUN.
- y_valid  in  1  y_data is valid this cycle.
- y_ready  out  1  block can accept y_data this cycle.
- y_data  in  YW  filtered sample, unsigned.
- x_valid  out  1  x_data holds a recovered sample.
- x_ready  in  1  downstream accepts x_data this cycle.
- x_data  out  XW  recovered sample.
- err  out  1  sticky flag: an out-of-range sample was detected.

Behaviour:
- Reset (rst=0): x_valid=0, x_data=0, err=0, history h1..h4=0, FSM=RUN. h1 is the most recent sample. History reset to zero matches the FIR's zeroed delay line.
- Recursion on each accepted y:
  - x_hat = y - 4*h1 - 16*h2 - 4*h3 - h4, in AW-bit signed arithmetic.
  - y is zero-extended. Multiplies are shifts (<<2, <<4).
- Range check:
  - 0 <= x_hat <= 15: sample is good.
  - Otherwise (negative or >15): sample is bad.
- Handshake:
  - Transfer on y when y_valid & y_ready. Transfer on x when x_valid & x_ready.
  - y_ready = (state==RUN) & (~x_valid | x_ready). Single output register, full throughput, no skid buffer.
  - Latency: an accepted y appears on x_data with x_valid=1 in the next cycle.
  - x_data and x_valid stay stable while x_valid & ~x_ready.
- FSM states: RUN, ERROR.
  - RUN, good sample accepted: x_data<=x_hat[3:0]; x_valid<=1; history shifts (h4<=h3, h3<=h2, h2<=h1, h1<=x_hat[3:0]).
  - RUN, bad sample accepted: enter ERROR; err<=1. History is not updated. x_valid is not set by this sample; a pending earlier x still drains normally.
  - ERROR: y_ready=0, so no further input is consumed. Stay in ERROR until clr=1 or rst=0.
  - RUN, no y transfer but x transfer: x_valid<=0.
- clr (with rst=1): same effect as reset on history, err, FSM and x_valid. clr takes priority over any simultaneous y or x transfer in that cycle, and that y is discarded.
- rst has priority over clr. Reset mid-stream discards the in-flight x.
- Widths:
  - Worst-case legal y is 390 (all x=15).
  - Any y with bits above bit 8 set is necessarily bad. The AW-bit math must still evaluate y=2^32-1 correctly as bad, with no wrap to a false good.

Decomposition:
- fir_pkg holds:
  - Coefficient constants C0=1, C1=4, C2=16.
  - Widths YW, XW, AW as localparams.
  - typedef enum {RUN, ERROR} deconv_state_t.
  - Pure function deconv_step(y, h1..h4) returning x_hat.
- One natural sub-module: fir_deconv_hist, a 4-deep XW-bit shift register. Inputs: clk, rst, clr, shift enable, data. Outputs: h1..h4.

Test Plan:
- Impulse: feed y=1,4,16,4,1,0 with x_ready=1 -> x_data=1,0,0,0,0,0, each one cycle after its y; err=0.
- Step: feed y=15,75,315,375,390,390 -> x_data=15 for all six; err=0.
- Backpressure: during the impulse stream, hold x_ready=0 for 3 cycles -> y_ready=0, x_data holds 1; on release the sequence continues unchanged with no loss or duplication.
- Error: after reset feed y=16 -> err=1 next cycle, x_valid stays 0, y_ready=0. Then pulse clr with no other change -> err=0, y_ready=1, and feeding y=1 yields x=1.
- Negative: feed y=1 then y=3 -> x=1, then err=1 (x_hat=-1); history keeps h1=1.
- Reset mid-stream: after y=1,4 accepted, drive rst=0 for one cycle -> x_valid=0 and err=0; then y=1 yields x=1, proving history was zeroed.
